// File: rtl/pong_pixel_engine.sv
// Pong game state (ball, paddle, score, lives, serve/play/miss/over FSM) and the registered pixel colour.
// Optional: define PONG_SPEEDUP_EN to raise ball speed by one on every 4th paddle hit (max 6).
module pong_pixel_engine #(
  parameter int SCREEN_W     = 640,
  parameter int SCREEN_H     = 480,
  parameter int BALL_SIZE    = 8,
  parameter int PADDLE_H     = 72,
  parameter int WALL_X       = 32,
  parameter int BALL_SPEED   = 2,
  parameter int PADDLE_SPEED = 4,
  parameter int SERVE_FRAMES = 60,
  parameter int LIVES        = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] h_pos,
  input  logic [9:0] v_pos,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_start,
  output logic [3:0] rgb,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic       game_over
);

  localparam int PADDLE_X = 600;
  localparam int PADDLE_W = 4;
  localparam int WALL_W   = 4;
  localparam int SC_W     = $clog2(SERVE_FRAMES);

  localparam logic [10:0] SW   = 11'(SCREEN_W);
  localparam logic [10:0] SH   = 11'(SCREEN_H);
  localparam logic [10:0] BS   = 11'(BALL_SIZE);
  localparam logic [10:0] PH   = 11'(PADDLE_H);
  localparam logic [10:0] PX   = 11'(PADDLE_X);
  localparam logic [10:0] PXR  = 11'(PADDLE_X + PADDLE_W);
  localparam logic [10:0] WX   = 11'(WALL_X);
  localparam logic [10:0] WXR  = 11'(WALL_X + WALL_W);
  localparam logic [10:0] PSPD = 11'(PADDLE_SPEED);
  localparam logic [10:0] PMAX = 11'(SCREEN_H - PADDLE_H);

  localparam logic [9:0] CX      = 10'(SCREEN_W / 2 - BALL_SIZE / 2);
  localparam logic [9:0] CY      = 10'(SCREEN_H / 2 - BALL_SIZE / 2);
  localparam logic [9:0] PY_INIT = 10'((SCREEN_H - PADDLE_H) / 2);
  localparam logic [9:0] BX_HIT  = 10'(PADDLE_X - BALL_SIZE);
  localparam logic [9:0] BY_MAX  = 10'(SCREEN_H - BALL_SIZE);
  localparam logic [9:0] BX_MIN  = 10'(WALL_X + WALL_W);
  localparam logic [SC_W-1:0] SERVE_LAST = SC_W'(SERVE_FRAMES - 1);

  typedef enum logic [1:0] {S_SERVE, S_PLAY, S_MISS, S_OVER} state_t;

  state_t          state_q, state_d;
  logic [SC_W-1:0] serve_cnt_q, serve_cnt_d;
  logic [9:0]      ball_x_q, ball_x_d, ball_y_q, ball_y_d, paddle_y_q, paddle_y_d;
  logic            dx_q, dx_d, dy_q, dy_d;   // dx 1 = right, dy 1 = down
  logic [3:0]      score_q, score_d, score_inc;
  logic [1:0]      lives_q, lives_d;
  logic [3:0]      rgb_q, rgb_d;
  logic            enter_serve;
  logic [10:0]     bx, by, py, hx, vy, spd;
  logic            in_ball, in_pad, in_wall;

`ifdef PONG_SPEEDUP_EN
  logic [2:0] ball_spd_q, ball_spd_d;
  assign spd = {8'd0, ball_spd_q};
`else
  assign spd = 11'(BALL_SPEED);
`endif

  assign bx        = {1'b0, ball_x_q};
  assign by        = {1'b0, ball_y_q};
  assign py        = {1'b0, paddle_y_q};
  assign score_inc = (score_q == 4'hF) ? 4'hF : score_q + 4'd1;

  always_comb begin
    state_d     = state_q;
    serve_cnt_d = serve_cnt_q;
    ball_x_d    = ball_x_q;
    ball_y_d    = ball_y_q;
    dx_d        = dx_q;
    dy_d        = dy_q;
    paddle_y_d  = paddle_y_q;
    score_d     = score_q;
    lives_d     = lives_q;
    enter_serve = 1'b0;
`ifdef PONG_SPEEDUP_EN
    ball_spd_d  = ball_spd_q;
`endif
    if (frame_tick) begin
      if (state_q != S_OVER) begin
        if (btn_up && !btn_down)
          paddle_y_d = (py < PSPD) ? 10'd0 : 10'(py - PSPD);
        else if (btn_down && !btn_up)
          paddle_y_d = (py + PSPD > PMAX) ? PMAX[9:0] : 10'(py + PSPD);
      end
      case (state_q)
        S_SERVE: begin
          enter_serve = 1'b1;
          if (serve_cnt_q == SERVE_LAST) state_d = S_PLAY;
          else                           serve_cnt_d = serve_cnt_q + 1'b1;
        end
        S_PLAY: begin
          if (!dy_q && by < spd) begin
            ball_y_d = 10'd0;
            dy_d     = 1'b1;
          end else if (dy_q && by + BS + spd > SH) begin
            ball_y_d = BY_MAX;
            dy_d     = 1'b0;
          end else begin
            ball_y_d = dy_q ? 10'(by + spd) : 10'(by - spd);
          end
          // hit test sees the paddle as it was before this tick's move
          if (!dx_q && bx < WXR + spd) begin
            ball_x_d = BX_MIN;
            dx_d     = 1'b1;
          end else if (dx_q && bx + BS <= PX && bx + BS + spd >= PX &&
                       by + BS > py && by < py + PH) begin
            ball_x_d = BX_HIT;
            dx_d     = 1'b0;
            score_d  = score_inc;
`ifdef PONG_SPEEDUP_EN
            if (score_q != 4'hF && score_inc[1:0] == 2'b00 && ball_spd_q < 3'd6)
              ball_spd_d = ball_spd_q + 3'd1;
`endif
          end else if (dx_q && bx + BS + spd >= SW) begin
            state_d  = S_MISS;
            ball_y_d = ball_y_q;
            dy_d     = dy_q;
          end else begin
            ball_x_d = dx_q ? 10'(bx + spd) : 10'(bx - spd);
          end
        end
        S_MISS: begin
          lives_d = lives_q - 2'd1;
          if (lives_q == 2'd1) state_d = S_OVER;
          else begin
            state_d     = S_SERVE;
            enter_serve = 1'b1;
          end
        end
        default: begin
          if (btn_start) begin
            score_d     = 4'd0;
            lives_d     = 2'(LIVES);
            state_d     = S_SERVE;
            enter_serve = 1'b1;
          end
        end
      endcase
      if (enter_serve) begin
        ball_x_d = CX;
        ball_y_d = CY;
        dx_d     = 1'b1;
        dy_d     = 1'b1;
        if (state_q != S_SERVE || serve_cnt_q == SERVE_LAST) serve_cnt_d = '0;
`ifdef PONG_SPEEDUP_EN
        if (state_q != S_SERVE) ball_spd_d = 3'(BALL_SPEED);
`endif
      end
    end
  end

  assign hx      = {1'b0, h_pos};
  assign vy      = {1'b0, v_pos};
  assign in_ball = hx >= bx && hx < bx + BS && vy >= by && vy < by + BS;
  assign in_pad  = hx >= PX && hx < PXR && vy >= py && vy < py + PH;
  assign in_wall = hx >= WX && hx < WXR;

  always_comb begin
    rgb_d = rgb_q;
    if (pix_en) begin
      if (!video_on)                                           rgb_d = 4'b0000;
      else if (in_ball && state_q != S_MISS && state_q != S_OVER) rgb_d = 4'b1111;
      else if (in_pad)                                         rgb_d = 4'b0010;
      else if (in_wall)                                        rgb_d = 4'b0100;
      else                                                     rgb_d = 4'b0001;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_SERVE;
      serve_cnt_q <= '0;
      ball_x_q    <= CX;
      ball_y_q    <= CY;
      dx_q        <= 1'b1;
      dy_q        <= 1'b1;
      paddle_y_q  <= PY_INIT;
      score_q     <= 4'd0;
      lives_q     <= 2'(LIVES);
      rgb_q       <= 4'b0000;
`ifdef PONG_SPEEDUP_EN
      ball_spd_q  <= 3'(BALL_SPEED);
`endif
    end else begin
      state_q     <= state_d;
      serve_cnt_q <= serve_cnt_d;
      ball_x_q    <= ball_x_d;
      ball_y_q    <= ball_y_d;
      dx_q        <= dx_d;
      dy_q        <= dy_d;
      paddle_y_q  <= paddle_y_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      rgb_q       <= rgb_d;
`ifdef PONG_SPEEDUP_EN
      ball_spd_q  <= ball_spd_d;
`endif
    end
  end

  assign rgb       = rgb_q;
  assign score     = score_q;
  assign lives     = lives_q;
  assign game_over = (state_q == S_OVER);

endmodule

// File: tb/tb_pong_pixel_engine.sv
// Scoreboard bench for pong_pixel_engine: a behavioural game model predicts score/lives/game_over
// per frame and the colour of probed pixels; DUT outputs are compared one cycle after each stimulus.
module tb_pong_pixel_engine;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pix_en = 1'b0;
  logic [9:0] h_pos = '0, v_pos = '0;
  logic       video_on = 1'b0, frame_tick = 1'b0;
  logic       btn_up = 1'b0, btn_down = 1'b0, btn_start = 1'b0;
  logic [3:0] rgb, score;
  logic [1:0] lives;
  logic       game_over;

  pong_pixel_engine dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_pos(h_pos), .v_pos(v_pos),
    .video_on(video_on), .frame_tick(frame_tick), .btn_up(btn_up), .btn_down(btn_down),
    .btn_start(btn_start), .rgb(rgb), .score(score), .lives(lives), .game_over(game_over)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- game model ----------------
  localparam int M_SERVE = 0, M_PLAY = 1, M_MISS = 2, M_OVER = 3;
  int m_bx, m_by, m_dx, m_dy, m_py, m_cnt, m_score, m_lives, m_st, m_spd;

  task automatic m_serve();
    m_bx = 316; m_by = 236; m_dx = 1; m_dy = 1; m_cnt = 0; m_spd = 2;
  endtask

  task automatic m_reset();
    m_serve();
    m_py = 204; m_score = 0; m_lives = 3; m_st = M_SERVE;
  endtask

  task automatic m_tick(input bit up, input bit dn, input bit st);
    int py0, nbx, nby, ndx, ndy;
    py0 = m_py;
    if (m_st != M_OVER) begin
      if (up && !dn)      m_py = (m_py - 4 < 0) ? 0 : m_py - 4;
      else if (dn && !up) m_py = (m_py + 4 > 408) ? 408 : m_py + 4;
    end
    case (m_st)
      M_SERVE: begin
        if (m_cnt == 59) begin m_cnt = 0; m_st = M_PLAY; end
        else m_cnt++;
      end
      M_PLAY: begin
        nbx = m_bx; nby = m_by; ndx = m_dx; ndy = m_dy;
        if (m_dy == 0 && m_by < m_spd)              begin nby = 0;   ndy = 1; end
        else if (m_dy == 1 && m_by + 8 + m_spd > 480) begin nby = 472; ndy = 0; end
        else nby = m_dy ? m_by + m_spd : m_by - m_spd;
        if (m_dx == 0 && m_bx < 36 + m_spd) begin nbx = 36; ndx = 1; end
        else if (m_dx == 1 && m_bx + 8 <= 600 && m_bx + 8 + m_spd >= 600 &&
                 m_by + 8 > py0 && m_by < py0 + 72) begin
          nbx = 592; ndx = 0;
          if (m_score < 15) begin
            m_score++;
`ifdef PONG_SPEEDUP_EN
            if (m_score % 4 == 0 && m_spd < 6) m_spd++;
`endif
          end
        end
        else if (m_dx == 1 && m_bx + 8 + m_spd >= 640) begin
          m_st = M_MISS; nbx = m_bx; nby = m_by; ndy = m_dy;
        end
        else nbx = m_dx ? m_bx + m_spd : m_bx - m_spd;
        m_bx = nbx; m_by = nby; m_dx = ndx; m_dy = ndy;
      end
      M_MISS: begin
        if (m_lives == 1) m_st = M_OVER;
        else begin m_st = M_SERVE; m_serve(); end
        m_lives--;
      end
      default: if (st) begin m_score = 0; m_lives = 3; m_st = M_SERVE; m_serve(); end
    endcase
  endtask

  function automatic logic [3:0] m_rgb(input int h, input int v, input bit vo);
    if (!vo) return 4'b0000;
    if (m_st != M_MISS && m_st != M_OVER && h >= m_bx && h < m_bx + 8 && v >= m_by && v < m_by + 8)
      return 4'b1111;
    if (h >= 600 && h <= 603 && v >= m_py && v < m_py + 72) return 4'b0010;
    if (h >= 32 && h <= 35) return 4'b0100;
    return 4'b0001;
  endfunction

  // ---------------- scoreboard ----------------
  typedef struct { int sc; int lv; int go; } fexp_t;
  fexp_t      fq[$];
  logic [3:0] rq[$];
  logic [3:0] last_rgb;

  task automatic probe(input int h, input int v, input bit vo);
    rq.push_back(m_rgb(h, v, vo));
    h_pos = 10'(h); v_pos = 10'(v); video_on = vo; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0; video_on = 1'b0;
    last_rgb = rq.pop_front();
    chk("rgb", rgb, last_rgb);
  endtask

  task automatic frame(input bit up, input bit dn, input bit st);
    fexp_t e;
    frame_tick = 1'b1; btn_up = up; btn_down = dn; btn_start = st; video_on = 1'b0;
    m_tick(up, dn, st);
    fq.push_back('{m_score, m_lives, (m_st == M_OVER) ? 1 : 0});
    @(posedge clk); #1;
    frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; btn_start = 1'b0;
    e = fq.pop_front();
    chk("score", score, e.sc);
    chk("lives", lives, e.lv);
    chk("game_over", game_over, e.go);
    probe(m_bx, m_by, 1);
    probe(m_bx + 7, m_by + 7, 1);
    probe(m_bx + 8, m_by + 3, 1);
    probe(m_bx - 1, m_by + 4, 1);
    probe(601, m_py, 1);
    probe(602, m_py + 71, 1);
    if (m_py > 0) probe(601, m_py - 1, 1);
    if (m_py < 408) probe(601, m_py + 72, 1);
  endtask

  function automatic bit [1:0] steer(input int target);
    if (m_py - target >= 2)  return 2'b10;
    if (target - m_py >= 2)  return 2'b01;
    return 2'b00;
  endfunction

  task automatic async_reset_check(input string tag);
    #3 rst = 1'b0;
    #1;
    chk({tag, "_rgb"}, rgb, 4'b0000);
    chk({tag, "_score"}, score, 4'd0);
    chk({tag, "_lives"}, lives, 2'd3);
    chk({tag, "_go"}, game_over, 1'b0);
    m_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
  endtask

  initial begin
    bit [1:0] b;
    int tgt;
    m_reset();
    #1;
    async_reset_check("por");

    // static pixel checks in SERVE
    probe(316, 236, 1);
    probe(323, 243, 1);
    probe(324, 236, 1);
    probe(33, 100, 1);
    probe(316, 236, 0);
    probe(601, 204, 1);
    probe(500, 100, 1);
    probe(316, 236, 1);
    h_pos = 10'd500; v_pos = 10'd100; video_on = 1'b0;
    @(posedge clk); #1;
    chk("hold_no_pix_en", rgb, last_rgb);

    // paddle to the top, hold up at 0, then all the way down
    repeat (54)  frame(1, 0, 0);
    repeat (120) frame(0, 1, 0);

    // track the ball to score hits
    for (int i = 0; i < 3000 && m_score < 4 && m_st != M_OVER; i++) begin
      b = steer(m_by - 32);
      frame(b[1], b[0], 0);
    end
    chk("hits_reached", (score >= 4) ? 1 : 0, 1);

    // reset mid-play with the ball visible on rgb
    probe(m_bx, m_by, 1);
    async_reset_check("mid");

    // dodge the ball until game over; cover the ball after it passes the hit window
    for (int i = 0; i < 3000 && m_st != M_OVER; i++) begin
      if (m_bx >= 594)        tgt = m_by - 4;
      else if (m_by + 12 <= 408) tgt = m_by + 12;
      else                    tgt = m_by - 76;
      b = steer(tgt);
      frame(b[1], b[0], 0);
    end
    chk("over_reached", game_over, 1'b1);
    repeat (4) frame(1, 0, 0);
    frame(0, 0, 1);
    chk("restart_go", game_over, 1'b0);
    repeat (3) frame(0, 0, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pong_pixel_engine.md
Name: pong_pixel_engine

Overview:
- Downstream of the VGA timing generator. Consumes its pixel coordinates, active-video flag and frame tick.
- Owns the Pong game state: ball, paddle, score, lives and the serve/play/miss/game-over FSM.
- Produces the registered 4-bit pixel colour driven to the DAC pins.
- Object positions update only on frame_tick, during vertical blanking. Pixel colour is evaluated every pix_en.

Parameters:
- SCREEN_W, 640, active width in pixels
- SCREEN_H, 480, active height in lines
- BALL_SIZE, 8, ball edge length (square)
- PADDLE_H, 72, paddle height; paddle x span 600..603
- WALL_X, 32, left wall x span 32..35
- BALL_SPEED, 2, ball pixels per frame per axis
- PADDLE_SPEED, 4, paddle pixels per frame
- SERVE_FRAMES, 60, frames the ball is held at centre before play
- LIVES, 3, misses allowed before game over

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- pix_en  in  1  pixel-rate enable (clk/2); all pixel-path registers advance only when high
- h_pos  in  10  current pixel x
- v_pos  in  10  current pixel y
- video_on  in  1  high inside the 640x480 active area
- frame_tick  in  1  one-clk pulse at start of vertical blanking
- btn_up  in  1  paddle up (synchronised upstream)
- btn_down  in  1  paddle down
- btn_start  in  1  restart from game over
- rgb  out  4  pixel colour
- score  out  4  paddle hits, saturating at 15
- lives  out  2  remaining lives
- game_over  out  1  high in state OVER

Behaviour:
- Reset (rst low, async; takes effect immediately, including mid-frame or mid-play):
  - Outputs: rgb=0000, score=0, lives=LIVES, game_over=0.
  - Internal: ball_x=316, ball_y=236, dx=+1 (right), dy=+1 (down), paddle_y=204, serve_cnt=0, state=SERVE.
- FSM states: SERVE, PLAY, MISS, OVER.
  - SERVE: ball held at (316,236), dx=+1, dy=+1. Each frame_tick increments serve_cnt. The tick with serve_cnt==SERVE_FRAMES-1 clears serve_cnt and moves to PLAY.
  - PLAY: ball update on each frame_tick (rules below).
  - MISS: lasts exactly one frame_tick. Decrements lives. Goes to OVER if lives was 1, otherwise to SERVE.
  - OVER: game_over=1, ball hidden. frame_tick with btn_start=1 sets score=0, lives=LIVES, state=SERVE.
- Ball update (PLAY, frame_tick); x and y rules are evaluated independently in the same tick:
  - y axis, dy up and ball_y<BALL_SPEED: ball_y<=0, dy<=down.
  - y axis, dy down and ball_y+BALL_SIZE+BALL_SPEED>SCREEN_H: ball_y<=472, dy<=up.
  - y axis, otherwise: ball_y += dy*BALL_SPEED.
  - x axis, dx left and ball_x<36+BALL_SPEED: ball_x<=36, dx<=right.
  - x axis, paddle hit when all hold: dx right, ball_x+BALL_SIZE<=600, ball_x+BALL_SIZE+BALL_SPEED>=600, ball_y+BALL_SIZE>paddle_y, ball_y<paddle_y+PADDLE_H. Then ball_x<=592, dx<=left, score<=min(score+1,15).
  - x axis, dx right and ball_x+BALL_SIZE+BALL_SPEED>=SCREEN_W: state<=MISS, ball position frozen.
  - x axis, otherwise: ball_x += dx*BALL_SPEED.
- Paddle (every state except OVER, on frame_tick):
  - btn_up only: paddle_y -= PADDLE_SPEED, clamped at 0.
  - btn_down only: paddle_y += PADDLE_SPEED, clamped at SCREEN_H-PADDLE_H (408).
  - Both or neither pressed: no move.
  - The paddle value used for the hit test is the pre-update paddle_y.
- Pixel path (on pix_en), with priority:
  - !video_on: 0000.
  - Ball pixel, state not MISS/OVER: 1111.
  - Paddle pixel: 0010.
  - Wall pixel: 0100.
  - Else: 0001.
- Inside tests: h_pos in [ball_x, ball_x+BALL_SIZE-1], v_pos in [ball_y, ball_y+BALL_SIZE-1]; likewise for paddle and wall.
- Latency: rgb is registered; it reflects h_pos/v_pos/video_on sampled on the previous pix_en (1 pixel).
- Arithmetic: 10-bit unsigned positions; comparisons done in 11 bits so no wrap-around occurs.
- frame_tick coinciding with video_on high is illegal upstream. If it occurs, the update is still applied.

Optional Feature:
- Macro PONG_SPEEDUP_EN.
- When defined:
  - Ball speed is register ball_spd (3 bits), set to BALL_SPEED on entering SERVE.
  - Every 4th paddle hit (score[1:0] becomes 00 after the increment) raises ball_spd by 1, up to 6.
  - All ball rules above use ball_spd in place of BALL_SPEED.
- When undefined: speed is constant BALL_SPEED and no ball_spd register exists.

Test Plan:
- Reset, then 60 frame_ticks, no buttons -> state PLAY on the 60th tick; ball at (316,236) until then; first PLAY tick gives (318,238).
- Paddle at 0, btn_up held for 3 ticks -> paddle_y stays 0. btn_down held for 120 ticks -> paddle_y=408, no overshoot.
- Ball at (590,200), dx right, paddle_y=180 -> next tick ball_x=592, dx left, score 0->1.
- Ball at (630,100), paddle_y=300 -> MISS, lives 3->2, then SERVE. After 3 such misses -> game_over=1, rgb never 1111. btn_start on a tick -> score=0, lives=3, SERVE.
- Pixel check at h=316,v=236 in SERVE -> rgb=1111 one pix_en later. h=33 -> 0100. video_on=0 -> 0000. Ball overlapping paddle pixel -> 1111.
- Assert rst mid-PLAY with ball at (400,50) -> all outputs at reset values immediately, without waiting for a clk edge. With PONG_SPEEDUP_EN, 4 hits -> ball_spd 2->3.
